image_rom_reader: RTL

- Reader side of the 2048x16 image ROM: drives its 11-bit word address and captures its 16-bit read data.
- Returns the data as a valid/ready pixel stream to the display or sprite path.
- The ROM cannot stall (CE and OCE are tied high) and has fixed read latency. The block therefore needs credit-based issue into a small return FIFO.
- It must also handle the ROM's bank select on ad[10], which is applied combinationally to already-registered data.

---
 rtl/image_rom_reader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/image_rom_reader.sv
// image_rom_reader: streams words out of the 2048x16 image ROM as a
// valid/ready pixel stream, with credit-based issue into a return FIFO.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, base, count frame request (count 0 means 2048 words)
//   busy, done         frame in progress / one-cycle end-of-frame pulse
//   rom_ad, rom_data   registered ROM address, ROM read data
//   pix_data, pix_valid, pix_ready, pix_last   output stream
//   stop_req           only with IMAGE_READER_LOOP_EN: end looping
//
// Optional build macro IMAGE_READER_LOOP_EN: repeat the frame without a
// gap until stop_req is seen; done and pix_last mark every frame end.
module image_rom_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
`ifdef IMAGE_READER_LOOP_EN
  input  logic              stop_req,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   cnt_eff;
  logic [ROM_LAT-1:0] vld_sr;
  logic [ROM_LAT-1:0] last_sr;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;

  logic accept_start;
  logic issue;
  logic issue_last;
  logic reload;
  logic loop_more;
  logic credit_ok;
  logic hazard;
  logic fifo_wr;
  logic fifo_rd;
  logic frame_end;
  logic [ADDR_W-1:0] reload_addr;
  logic [ADDR_W:0]   reload_cnt;

  assign cnt_eff = (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;

`ifdef IMAGE_READER_LOOP_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic              stop_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      count_q   <= '0;
      stop_seen <= 1'b0;
    end else begin
      if (accept_start) begin
        base_q  <= base;
        count_q <= cnt_eff;
      end
      if (state == S_IDLE)
        stop_seen <= 1'b0;
      else if (stop_req)
        stop_seen <= 1'b1;
    end
  end

  assign loop_more   = !(stop_seen || stop_req);
  assign reload_addr = base_q;
  assign reload_cnt  = count_q;
`else
  assign loop_more   = 1'b0;
  assign reload_addr = '0;
  assign reload_cnt  = '0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++)
      inflight = inflight + CW'(vld_sr[i]);
  end

  assign busy      = (state != S_IDLE);
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = fifo_data[rd_ptr];
  assign pix_last  = pix_valid & fifo_last[rd_ptr];

  assign fifo_wr   = vld_sr[ROM_LAT-1];
  assign fifo_rd   = pix_valid & pix_ready;
  assign frame_end = fifo_rd & pix_last;

  // Credit: every in-flight read already owns a FIFO slot.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count})
                     < (CW+1)'(FIFO_DEPTH);

  // The ROM bank mux follows the live ad[MSB], so a bank change must
  // wait until no earlier read is still travelling through the ROM.
  assign hazard = (next_addr[ADDR_W-1] != rom_ad[ADDR_W-1])
                  && (inflight != '0);

  assign issue_last = (remaining == (ADDR_W+1)'(1));

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    issue        = 1'b0;
    reload       = 1'b0;
    unique case (state)
      S_IDLE: begin
        // done still high means the previous frame just closed
        if (start && !done) begin
          accept_start = 1'b1;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = (remaining != '0) && credit_ok && !hazard;
        if (issue && issue_last) begin
          if (loop_more)
            reload = 1'b1;
          else
            state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // only the final word left anywhere in the pipe
        if (frame_end && inflight == '0
            && fifo_count == CW'(1))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      rom_ad    <= '0;
      next_addr <= '0;
      remaining <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
    end else begin
      state <= state_nxt;
      done  <= frame_end;
      if (accept_start) begin
        next_addr <= base;
        remaining <= cnt_eff;
      end else if (issue) begin
        rom_ad <= next_addr;
        if (reload) begin
          next_addr <= reload_addr;
          remaining <= reload_cnt;
        end else begin
          next_addr <= next_addr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
        end
      end
      vld_sr[0]  <= issue;
      last_sr[0] <= issue & issue_last;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_data[i] <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_last[wr_ptr] <= last_sr[ROM_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (fifo_rd)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(fifo_wr && !fifo_rd && fifo_count == CW'(FIFO_DEPTH))
  );

endmodule
